// File: rtl/d_flip_flop.sv
// d_flip_flop: rising-edge D register with clock enable, synchronous clear, async active-low reset
// and complemented output. Define DFF_SCAN_EN to add a serial scan chain (scan_en/scan_in/scan_out).
module d_flip_flop #(
    parameter int unsigned      WIDTH       = 1,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0,
    parameter logic [WIDTH-1:0] CLEAR_VALUE = '0
) (
    input  logic             C,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] D,
    input  logic             en,
    input  logic             clr,
`ifdef DFF_SCAN_EN
    input  logic             scan_en,
    input  logic             scan_in,
    output logic             scan_out,
`endif
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] notQ
);

`ifdef DFF_SCAN_EN
    logic [WIDTH-1:0] shifted;

    // A one-bit register has no lower bits to shift, so it simply loads scan_in.
    generate
        if (WIDTH == 1) begin : g_scan_narrow
            assign shifted = scan_in;
        end else begin : g_scan_wide
            assign shifted = {Q[WIDTH-2:0], scan_in};
        end
    endgenerate

    assign scan_out = Q[WIDTH-1];

    always_ff @(posedge C or negedge rst_n) begin
        if (!rst_n) begin
            Q <= RESET_VALUE;
        end else if (scan_en) begin
            Q <= shifted;
        end else if (clr) begin
            Q <= CLEAR_VALUE;
        end else if (en) begin
            Q <= D;
        end
    end
`else
    always_ff @(posedge C or negedge rst_n) begin
        if (!rst_n) begin
            Q <= RESET_VALUE;
        end else if (clr) begin
            Q <= CLEAR_VALUE;
        end else if (en) begin
            Q <= D;
        end
    end
`endif

    // Complement is derived from the stored value, so it can never disagree with Q.
    assign notQ = ~Q;

endmodule

// File: tb/tb_d_flip_flop.sv
// Directed self-checking bench for d_flip_flop: 1-bit and 8-bit instances, plus a 4-bit
// scan instance when DFF_SCAN_EN is defined.
module tb_d_flip_flop;

    logic       C = 1'b0;
    logic       rst_n = 1'b1;
    logic       d1, en1, clr1;
    logic [0:0] q1, nq1;
    logic [7:0] d8, q8, nq8;
    logic       en8, clr8;

    int unsigned tests = 0;
    int unsigned failed = 0;

    always #5 C = ~C;

    d_flip_flop #(.WIDTH(1)) u_dff1 (
        .C(C), .rst_n(rst_n), .D(d1), .en(en1), .clr(clr1),
`ifdef DFF_SCAN_EN
        .scan_en(1'b0), .scan_in(1'b0), .scan_out(),
`endif
        .Q(q1), .notQ(nq1)
    );

    d_flip_flop #(.WIDTH(8), .RESET_VALUE(8'h3C), .CLEAR_VALUE(8'h00)) u_dff8 (
        .C(C), .rst_n(rst_n), .D(d8), .en(en8), .clr(clr8),
`ifdef DFF_SCAN_EN
        .scan_en(1'b0), .scan_in(1'b0), .scan_out(),
`endif
        .Q(q8), .notQ(nq8)
    );

`ifdef DFF_SCAN_EN
    logic [3:0] d4, q4, nq4;
    logic       scan_en4, scan_in4, scan_out4, clr4;

    d_flip_flop #(.WIDTH(4)) u_dff4 (
        .C(C), .rst_n(rst_n), .D(d4), .en(1'b1), .clr(clr4),
        .scan_en(scan_en4), .scan_in(scan_in4), .scan_out(scan_out4),
        .Q(q4), .notQ(nq4)
    );
`endif

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        d1 = 1'b1; en1 = 1'b1; clr1 = 1'b0;
        d8 = 8'h00; en8 = 1'b0; clr8 = 1'b0;
`ifdef DFF_SCAN_EN
        d4 = 4'hF; scan_en4 = 1'b0; scan_in4 = 1'b0; clr4 = 1'b0;
`endif
        // Reset pulse while C is low, before the first rising edge at t=5.
        #1 rst_n = 1'b0;
        #1;
        check("rst_q1", q1, 1'b0);
        check("rst_nq1", nq1, 1'b1);
        check("rst_q8", q8, 8'h3C);
        check("rst_nq8", nq8, 8'hC3);
        #1 rst_n = 1'b1;
        #1;
        check("post_release_q1", q1, 1'b0);

        @(posedge C); #1;
        check("first_capture_q1", q1, 1'b1);
        check("first_capture_nq1", nq1, 1'b0);

        // D drops during the high phase: no effect until the next rising edge.
        #2 d1 = 1'b0;
        #1 check("mid_high_q1", q1, 1'b1);
        @(negedge C); #1;
        check("after_fall_q1", q1, 1'b1);
        @(posedge C); #1;
        check("capture0_q1", q1, 1'b0);
        check("capture0_nq1", nq1, 1'b1);

        d1 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge C); #1;
            check("toggle_rise_q1", q1, 1'b1);
            @(negedge C); #1;
            check("toggle_fall_q1", q1, 1'b1);
        end

        // 8-bit: enable low holds, then capture, clear priority over enable.
        d8 = 8'hA5; en8 = 1'b0;
        @(posedge C); #1;
        check("en0_hold_q8", q8, 8'h3C);
        en8 = 1'b1;
        @(posedge C); #1;
        check("en1_q8", q8, 8'hA5);
        check("en1_nq8", nq8, 8'h5A);
        clr8 = 1'b1; d8 = 8'hFF;
        @(posedge C); #1;
        check("clr_en1_q8", q8, 8'h00);
        check("clr_en1_nq8", nq8, 8'hFF);
        clr8 = 1'b0; d8 = 8'hA5;
        @(posedge C); #1;
        check("reload_q8", q8, 8'hA5);
        clr8 = 1'b1; en8 = 1'b0;
        @(posedge C); #1;
        check("clr_en0_q8", q8, 8'h00);
        clr8 = 1'b0; en8 = 1'b1;
        @(posedge C); #1;
        check("reload2_q8", q8, 8'hA5);

        // D wiggles with C low: no capture without a rising edge.
        @(negedge C); #1 d8 = 8'h0F;
        #2 check("low_phase_d_q8", q8, 8'hA5);
        d8 = 8'hA5;

        // Reset mid-operation with C low, then a rising edge while still in reset.
        #1 rst_n = 1'b0;
        #1;
        check("mid_rst_q8", q8, 8'h3C);
        check("mid_rst_q1", q1, 1'b0);
        @(posedge C); #1;
        check("edge_in_rst_q8", q8, 8'h3C);
        check("edge_in_rst_nq8", nq8, 8'hC3);
        check("edge_in_rst_q1", q1, 1'b0);
        @(negedge C); #1 rst_n = 1'b1;
        #1 check("released_q8", q8, 8'h3C);
        @(posedge C); #1;
        check("after_release_q8", q8, 8'hA5);
        check("after_release_q1", q1, 1'b1);

`ifdef DFF_SCAN_EN
        // Scan shifts in 1,0,1,1 MSB-ward; clr held high to exercise scan priority.
        rst_n = 1'b0;
        #1 check("scan_rst_q4", q4, 4'b0000);
        @(negedge C); #1 rst_n = 1'b1;
        scan_en4 = 1'b1; clr4 = 1'b1;
        scan_in4 = 1'b1; @(posedge C); #1 check("scan1_q4", q4, 4'b0001);
        scan_in4 = 1'b0; @(posedge C); #1 check("scan2_q4", q4, 4'b0010);
        scan_in4 = 1'b1; @(posedge C); #1 check("scan3_q4", q4, 4'b0101);
        scan_in4 = 1'b1; @(posedge C); #1 check("scan4_q4", q4, 4'b1011);
        check("scan4_nq4", nq4, 4'b0100);
        check("scan_out", scan_out4, 1'b1);
        scan_en4 = 1'b0;
        @(posedge C); #1 check("scan_off_clr_q4", q4, 4'b0000);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/d_flip_flop.md
Name: d_flip_flop

Overview:
- Positive-edge-triggered D-type storage register with true and complemented outputs.
- Default WIDTH=1 gives the project's basic single-bit flip-flop. It is the primitive state element for the game logic: debounced key capture and score/state bits.
- Wider instances store a bus with one shared clock, async reset, clock enable and synchronous clear.

Parameters:
- WIDTH, 1, number of stored bits (1..64).
- RESET_VALUE, 0 (WIDTH bits), value loaded into Q on asynchronous reset.
- CLEAR_VALUE, 0 (WIDTH bits), value loaded into Q on synchronous clear.

Ports:
- C  input  1  clock; state updates on rising edge only.
- rst_n  input  1  asynchronous active-low reset.
- D  input  WIDTH  data to capture.
- en  input  1  clock enable; tie 1 for plain DFF behaviour.
- clr  input  1  synchronous clear, active-high.
- Q  output  WIDTH  stored value.
- notQ  output  WIDTH  bitwise complement of Q.

Behaviour:
- Interface: one clock (C); reset (rst_n) is asynchronous and active-low.
- Reset:
  - rst_n=0 immediately forces Q=RESET_VALUE and notQ=~RESET_VALUE, independent of C.
  - Reset held low overrides all other inputs.
  - Deassertion is asynchronous. The first capture occurs on the first rising C edge with rst_n=1.
- Priority on each rising C edge with rst_n=1:
  - clr=1: Q<=CLEAR_VALUE, regardless of en.
  - Else en=1: Q<=D.
  - Else: Q holds.
- Latency:
  - Q reflects D captured at a rising edge, visible after that edge (one-edge latency).
  - No combinational path from D to Q.
- Level and falling-edge immunity:
  - Changes on D while C is high or low produce no change in Q.
  - Falling C edges produce no change in Q.
- notQ is always exactly ~Q, bit for bit. It is derived combinationally from the stored register, not separately stored. No cycle exists where notQ==Q.
- Reset mid-operation: asserting rst_n between edges changes Q at once. A rising edge coincident with rst_n=0 is ignored.
- Simultaneous D change at the rising edge: D must meet setup/hold. Simulation samples D before the edge (nonblocking update).
- Before the first reset, Q is undefined. A bench must pulse rst_n before checking values.
- Width rule: all bits behave identically and independently. There is no cross-bit logic except the scan chain in the optional feature below.

Optional Feature:
- Macro DFF_SCAN_EN.
- When defined, adds three ports:
  - scan_en, input, 1 bit.
  - scan_in, input, 1 bit.
  - scan_out, output, 1 bit, equal to Q[WIDTH-1].
- With scan_en=1, a rising C edge (rst_n=1) shifts: Q <= {Q[WIDTH-2:0], scan_in}. For WIDTH=1, Q <= scan_in.
- Scan has priority over clr and en.
- notQ still tracks ~Q.
- Async reset still overrides scan.
- When not defined, these ports do not exist and behaviour is exactly as above.

Test Plan:
- WIDTH=1, rst_n pulse low then high, en=1, clr=0, D=1, C=0 -> Q=0, notQ=1. First C rise -> Q=1, notQ=0.
- With Q=1 and C high, set D=0 mid-high phase -> Q stays 1 through the C fall. Next C rise -> Q=0, notQ=1.
- Toggle C repeatedly with D constant at 1 -> Q remains 1 on every edge; falling edges cause no change.
- WIDTH=8, D=8'hA5, en=0, C rise -> Q holds the prior value. Set en=1, C rise -> Q=8'hA5, notQ=8'h5A. Set clr=1 with en=1 and D=8'hFF, C rise -> Q=8'h00.
- Q=8'hA5, drop rst_n between edges with C low -> Q=RESET_VALUE immediately. A C rise with rst_n=0 -> no capture.
- With DFF_SCAN_EN defined, WIDTH=4, Q=4'b0000, scan_en=1, scan_in sequence 1,0,1,1 over 4 rising edges -> Q=4'b1011. scan_out reads 1 after the 4th edge.
